uart_tx_buffer: RTL and testbench
=================================

UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, FIFO entry count; power of two, minimum 2.
REQ-002 The block SHALL have parameter ACK_TIMEOUT, default 15, clk cycles to wait for busy to rise after send_req.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 wr_en  input  1  CPU push strobe, one byte per cycle.
REQ-006 wr_data  input  8  byte to push.
REQ-007 full  output  1  FIFO holds DEPTH entries.
REQ-008 empty  output  1  FIFO holds 0 entries.
REQ-009 count  output  log2(DEPTH)+1  current entry count.
REQ-010 busy  input  1  UART transmitter busy, from the transmitter.
REQ-011 send_req  output  1  one-cycle request to the transmitter.
REQ-012 tx_byte  output  8  byte presented to the transmitter.
REQ-013 overflow  output  1  sticky; a push was dropped.
REQ-014 ack_err  output  1  sticky; transmitter never acknowledged a request.
REQ-015 flag_clr  input  1  clears overflow and ack_err.

Function
REQ-016 Push: wr_en=1 with full=0 SHALL store wr_data at wptr; wptr increments modulo DEPTH.
REQ-017 Push with full=1 SHALL be dropped with no state change except overflow<=1.
REQ-018 full, empty and count SHALL be derived from the registered count: full = (count==DEPTH); empty = (count==0).
REQ-019 FSM states SHALL be IDLE, LOAD, REQ, WAIT_ACK and WAIT_DONE.
REQ-020 IDLE SHALL go to LOAD when empty=0 and busy=0; otherwise it stays in IDLE.
REQ-021 LOAD SHALL perform the following, then go to REQ:
- tx_byte <= mem[rptr]
- rptr increments modulo DEPTH
- count decrements (pop)
REQ-022 REQ SHALL drive send_req=1 for exactly one cycle, clear the timeout counter, then go to WAIT_ACK.
REQ-023 In WAIT_ACK, busy=1 SHALL go to WAIT_DONE; otherwise the timer increments.
REQ-024 In WAIT_ACK, when the timer reaches ACK_TIMEOUT with busy still 0, the block SHALL set ack_err, go to IDLE and discard the byte (no retry).
REQ-025 WAIT_DONE SHALL go to IDLE when busy=0.
REQ-026 send_req SHALL be 0 in every state other than REQ.
REQ-027 tx_byte SHALL hold its value from LOAD until the next LOAD.
REQ-028 A push and a pop in the same cycle SHALL both succeed, leaving count unchanged.
REQ-029 A push while full=1 coinciding with a pop SHALL still be rejected, because full is evaluated before the edge.
REQ-030 Latency: when a byte is pushed at edge E into an empty FIFO with the FSM in IDLE and busy=0:
- LOAD is entered at E+1.
- send_req=1 and tx_byte valid in the cycle following E+2.
REQ-031 Back-to-back bytes SHALL be separated by at least LOAD+REQ, so there are at least 2 cycles between busy falling and the next send_req.
REQ-032 flag_clr=1 SHALL clear overflow and ack_err; a set event in the same cycle SHALL take priority.
REQ-033 Pointer wrap-around SHALL be transparent: DEPTH pushes followed by DEPTH pops return the bytes in order.

Reset
REQ-034 reset=0 SHALL immediately, without waiting for a clock edge, force the following:
- wptr=rptr=0, count=0
- FSM to IDLE
- send_req=0, tx_byte=8'h00
- overflow=0, ack_err=0
- consequently empty=1, full=0
REQ-035 Reset mid-transfer SHALL abort the transfer and discard all buffered bytes; the storage array is not required to be reset.
REQ-036 After reset deasserts, the first push SHALL behave per REQ-030.

Verification
REQ-037 Push 8'hA5 with busy held 0 → send_req pulses one cycle in the cycle after E+2 with tx_byte=8'hA5; count returns to 0.
REQ-038 Push 17 bytes 8'h00..8'h10 while busy=1 (DEPTH=16) → full=1 after 16 pushes, overflow=1, count=16; the byte 8'h10 is dropped.
REQ-039 Drain a full FIFO with a transmitter model (busy rises 1 cycle after send_req and stays high 10 cycles) → 16 send_req pulses, bytes in order, pointers wrap, empty=1 at end.
REQ-040 Busy never rises after send_req → ack_err=1 exactly ACK_TIMEOUT cycles into WAIT_ACK, FSM back in IDLE, next byte sent normally; flag_clr clears ack_err.
REQ-041 Push and pop in the same cycle at count=5 → count stays 5; push while full coinciding with a pop → push rejected and overflow=1.
REQ-042 Assert reset=0 during WAIT_DONE with count=3 → all outputs reach reset values asynchronously; after release, a push of 8'h3C is transmitted first.

Source files
------------

// File: rtl/uart_tx_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : uart_tx_buffer                                             |
// | Brief    : CPU-side byte FIFO that feeds a UART transmitter through a |
// |            send_req/busy handshake with an acknowledge timeout.       |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module uart_tx_buffer #(
    parameter int DEPTH       = 16,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     busy,
    output logic                     send_req,
    output logic [7:0]               tx_byte,
    output logic                     overflow,
    output logic                     ack_err,
    input  logic                     flag_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    localparam logic [CW-1:0] c_DEPTH    = CW'(DEPTH);
    localparam logic [TW-1:0] c_TMO_LAST = TW'(ACK_TIMEOUT - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_REQ       = 3'd2;
    localparam logic [2:0] S_WAIT_ACK  = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [2:0]    r_state;
    logic [TW-1:0] r_timer;
    logic          r_send_req;
    logic [7:0]    r_tx_byte;
    logic          r_overflow;
    logic          r_ack_err;
    logic          w_push;
    logic          w_pop;

    // full is sampled before the edge, so a push into a full FIFO is
    // rejected even when the FSM pops in the same cycle.
    assign w_push   = wr_en & ~full;
    assign w_pop    = (r_state == S_LOAD);

    assign full     = (r_count == c_DEPTH);
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign send_req = r_send_req;
    assign tx_byte  = r_tx_byte;
    assign overflow = r_overflow;
    assign ack_err  = r_ack_err;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_send_req <= 1'b0;
            r_tx_byte  <= 8'h00;
            r_overflow <= 1'b0;
            r_ack_err  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (wr_en && full) begin
                r_overflow <= 1'b1;
            end else if (flag_clr) begin
                r_overflow <= 1'b0;
            end

            // Clear first; a timeout below in the same cycle wins.
            if (flag_clr) begin
                r_ack_err <= 1'b0;
            end

            r_send_req <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!empty && !busy) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_tx_byte  <= r_mem[r_rptr];
                    r_rptr     <= r_rptr + 1'b1;
                    r_send_req <= 1'b1;
                    r_state    <= S_REQ;
                end
                S_REQ: begin
                    r_timer <= '0;
                    r_state <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (busy) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_timer == c_TMO_LAST) begin
                        r_ack_err <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!busy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_uart_tx_buffer                                          |
// | Brief    : Directed self-checking bench for uart_tx_buffer with a     |
// |            byte scoreboard and a simple transmitter model.            |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module tb_uart_tx_buffer;

    localparam int DEPTH       = 16;
    localparam int ACK_TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       busy;
    logic       send_req;
    logic [7:0] tx_byte;
    logic       overflow;
    logic       ack_err;
    logic       flag_clr;

    logic       f_busy;
    logic       m_busy;
    logic       tx_mode;
    int         bcnt;
    logic       prev_req;

    int checks = 0;
    int errors = 0;
    int sends  = 0;
    logic [7:0] sb [$];

    assign busy = f_busy | m_busy;

    uart_tx_buffer #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .busy(busy),
        .send_req(send_req), .tx_byte(tx_byte), .overflow(overflow),
        .ack_err(ack_err), .flag_clr(flag_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transmitter: busy rises the cycle after send_req and stays high 10 cycles.
    always @(posedge clk) begin
        if (!reset) begin
            m_busy <= 1'b0;
            bcnt   <= 0;
        end else if (tx_mode && send_req && bcnt == 0) begin
            m_busy <= 1'b1;
            bcnt   <= 10;
        end else if (bcnt != 0) begin
            bcnt <= bcnt - 1;
            if (bcnt == 1) m_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (send_req) begin
            check("req_single_cycle", 32'(prev_req), 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_send", 32'(tx_byte), 32'hFFFF);
            end else begin
                check("tx_byte", 32'(tx_byte), 32'(sb.pop_front()));
            end
            sends++;
        end
        prev_req = send_req;
    end

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = d;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    task automatic wait_sends(input string tag, input int n, input int budget);
        int t = 0;
        while (sends < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        check(tag, 32'(sends), 32'(n));
        repeat (15) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; wr_en = 1'b0; wr_data = 8'h00; flag_clr = 1'b0;
        f_busy = 1'b0; tx_mode = 1'b0; prev_req = 1'b0;
        #2;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_send_req", 32'(send_req), 32'd0);
        check("rst_tx_byte", 32'(tx_byte), 32'h00);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Single byte, busy held low: latency, then acknowledge timeout.
        sb.push_back(8'hA5);
        push(8'hA5);
        @(negedge clk);
        check("lat_e0_req", 32'(send_req), 32'd0);
        check("lat_e0_count", 32'(count), 32'd1);
        @(negedge clk);
        check("lat_e1_req", 32'(send_req), 32'd0);
        @(negedge clk);
        check("lat_e2_req", 32'(send_req), 32'd1);
        check("lat_e2_count", 32'(count), 32'd0);
        @(negedge clk);
        check("lat_e3_req", 32'(send_req), 32'd0);
        repeat (14) @(negedge clk);
        check("ack_err_early", 32'(ack_err), 32'd0);
        @(negedge clk);
        check("ack_err_set", 32'(ack_err), 32'd1);
        tx_mode = 1'b1;
        sb.push_back(8'h5A);
        push(8'h5A);
        wait_sends("after_timeout_send", 2, 60);
        @(negedge clk); flag_clr = 1'b1;
        @(negedge clk); flag_clr = 1'b0;
        check("ack_err_clr", 32'(ack_err), 32'd0);

        // Fill past capacity with the transmitter busy.
        f_busy = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            if (i < DEPTH) sb.push_back(8'(i));
            push(8'(i));
            if (i == DEPTH - 1) check("full_at_16", 32'(full), 32'd1);
        end
        @(negedge clk);
        check("fill_count", 32'(count), 32'd16);
        check("fill_overflow", 32'(overflow), 32'd1);
        check("fill_full", 32'(full), 32'd1);
        flag_clr = 1'b1;
        @(negedge clk); flag_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);

        // Drain through the wrap with the transmitter model.
        f_busy = 1'b0;
        wait_sends("drain_sends", 2 + DEPTH, 400);
        check("drain_empty", 32'(empty), 32'd1);

        // Simultaneous push and pop at count 5.
        f_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sb.push_back(8'h40 + 8'(i));
            push(8'h40 + 8'(i));
        end
        sb.push_back(8'h55);
        @(negedge clk); f_busy = 1'b0;
        @(negedge clk); wr_en = 1'b1; wr_data = 8'h55;
        @(posedge clk); #1 wr_en = 1'b0;
        @(negedge clk);
        check("pushpop_count", 32'(count), 32'd5);
        wait_sends("pushpop_sends", 2 + DEPTH + 6, 200);

        // Push while full coinciding with a pop is rejected.
        f_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            sb.push_back(8'h80 + 8'(i));
            push(8'h80 + 8'(i));
        end
        @(negedge clk); f_busy = 1'b0;
        @(negedge clk); wr_en = 1'b1; wr_data = 8'hEE;
        @(posedge clk); #1 wr_en = 1'b0;
        @(negedge clk);
        check("fullpop_count", 32'(count), 32'd15);
        check("fullpop_overflow", 32'(overflow), 32'd1);
        wait_sends("fullpop_sends", 2 + 2 * DEPTH + 6, 400);

        // Asynchronous reset in WAIT_DONE with three bytes still buffered.
        f_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(8'h30 + 8'(i));
            push(8'h30 + 8'(i));
        end
        @(negedge clk); f_busy = 1'b0;
        repeat (4) @(negedge clk);
        check("wd_count", 32'(count), 32'd3);
        check("wd_busy", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_full", 32'(full), 32'd0);
        check("arst_overflow", 32'(overflow), 32'd0);
        check("arst_ack_err", 32'(ack_err), 32'd0);
        check("arst_tx_byte", 32'(tx_byte), 32'h00);
        sb.delete();
        @(negedge clk); reset = 1'b1;
        sends = 0;
        sb.push_back(8'h3C);
        push(8'h3C);
        repeat (3) @(negedge clk);
        check("post_rst_req", 32'(send_req), 32'd1);
        wait_sends("post_rst_sends", 1, 60);
        check("post_rst_empty", 32'(empty), 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout observed=1 expected=0");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
